fpu_addsub_unit: RTL
====================

# fpu_addsub_unit

Parametrised IEEE-754 adder/subtractor and the successor to the single-precision FPU adder in the FPU datapath. It supports configurable exponent and mantissa widths and a run-time add/sub select. It performs correct sign handling, round-to-nearest-even and special-value handling, and raises exception flags. Latency is fixed and the handshake is start/done, so the CNN accumulation path can schedule it statically.

## Interface
- EXP_W, 8, exponent field width (≥4)
- MAN_W, 23, stored mantissa field width (≥4); word width W = 1+EXP_W+MAN_W

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- start  in  1  operand strobe, sampled only in IDLE
- op_sub  in  1  0 = a+b, 1 = a−b; sampled with start
- a_in  in  W  operand A, sampled with start
- b_in  in  W  operand B, sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse; result/flags valid
- result  out  W  packed result, held until the next done
- flags  out  4  [3] invalid, [2] overflow, [1] underflow, [0] inexact; held with result

## Operation
- FSM: IDLE→UNPACK→ALIGN→ADD→NORM→ROUND→IDLE. Every state except IDLE lasts exactly one cycle. No data-dependent latency.
- UNPACK:
  - Subnormal inputs are flushed to zero of the same sign.
  - Effective sign of B is b_s^op_sub. Effective subtract is a_s^b_s^op_sub.
  - Operands are swapped so that the larger magnitude (exponent, then significand) is X.
  - Special cases are classified here and set a bypass value. The bypass still traverses all states.
- Special cases:
  - Any NaN input gives canonical qNaN: sign 0, exp all-ones, mantissa MSB 1, rest 0. invalid is set only if an input is sNaN (mantissa MSB 0).
  - inf−inf (effective) gives qNaN with invalid.
  - inf±finite gives that inf.
  - Both inputs zero: the sign is the AND of the effective signs for add, else +0.
- ALIGN:
  - Significands are SIG_W = MAN_W+1 bits with the hidden 1, extended by guard, round and sticky (SIG_W+3 bits).
  - Y is right-shifted by the exponent difference. Bits shifted out OR into sticky.
  - If the difference is ≥ SIG_W+3, Y becomes sticky-only.
- ADD: a SIG_W+4-bit add or subtract, X−Y ≥ 0 always. An exact zero from subtract gives +0.
- NORM:
  - On carry-out, shift right by 1 (sticky preserved) and increment the exponent.
  - Otherwise shift left by the leading-zero count and subtract it from the exponent.
- ROUND:
  - Rounding is RNE on G/R/S.
  - Mantissa carry from rounding renormalises and increments the exponent.
  - inexact = G|R|S before rounding.
  - Exponent ≥ all-ones gives ±inf with overflow|inexact.
  - Exponent ≤ 0 gives signed zero with underflow|inexact (flush-to-zero output).
- start while busy is ignored. op_sub/a_in/b_in are registered at acceptance, so later changes have no effect.

## Timing
- start high at rising edge N (FSM in IDLE) → busy=1 from N+1 through N+5. done=1 for the cycle following edge N+5, with result and flags valid then. Latency is 6 cycles.
- A back-to-back start is accepted on the edge where done is high (FSM has returned to IDLE), giving throughput of 1 op per 6 cycles.
- Reset values: busy=0, done=0, result=0, flags=0, FSM=IDLE.
- rst_n low mid-operation aborts at the next edge: outputs return to reset values, no done is emitted, and the in-flight operation is lost.
- start and rst_n low on the same edge: reset wins.

## Structure
- Package fpu_pkg contains:
  - the FSM state enum
  - flag bit index constants
  - function qnan(EXP_W, MAN_W)
  - the field-extract helper functions (sign, exp, mantissa, is_nan, is_snan, is_inf, is_zero)
- Sub-module fpu_lzc: parametrised combinational leading-zero counter (WIDTH), used in NORM. Output width is $clog2(WIDTH+1).
- Everything else stays in one module. Each stage's working values are registered.

## Test plan
- Default params: 0x3F800000 + 0x40000000, op_sub=0 → result 0x40400000, flags 0, done exactly 6 cycles after start. With EXP_W=5, MAN_W=10: 0x3C00+0x3C00 → 0x4000.
- 0x3F800000 − 0x3F800000 (op_sub=1) → 0x00000000, flags 0. 0xC0000000 + 0x3F800000 → 0xBF800000.
- RNE: 0x3F800000 + 0x33800000 → 0x3F800000, flags 0x1. 0x3F800001 + 0x33800000 → 0x3F800002, flags 0x1.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags 0x5. 0x7F800000 − 0x7F800000 (op_sub=1) → 0x7FC00000, flags 0x8. 0x7FA00000 + 1.0 → 0x7FC00000, flags 0x8.
- Subnormal input 0x00000001 + 0x00000000 → 0x00000000, flags 0. Underflow: 0x00800001 − 0x00800000 → 0x00000000, flags 0x3.
- Control: start pulsed while busy → ignored, one done only. rst_n low on cycle 3 of an operation → busy/done/result/flags 0, no done. A subsequent 1.0+1.0 → 0x40000000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and IEEE-754 field helpers for the parametrised FPU add/sub datapath.
// Helpers take the word zero-extended to 64 bits plus the field widths, so W is limited to 64.
package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND
  } state_t;

  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_INEXACT   = 0;

  localparam int unsigned MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t field_mask(input int unsigned width);
    return (word_t'(1) << width) - word_t'(1);
  endfunction

  function automatic word_t qnan(input int unsigned exp_w, input int unsigned man_w);
    return (field_mask(exp_w) << man_w) | (word_t'(1) << (man_w - 1));
  endfunction

  function automatic logic fp_sign(input word_t w, input int unsigned exp_w, input int unsigned man_w);
    word_t t;
    t = w >> (exp_w + man_w);
    return t[0];
  endfunction

  function automatic word_t fp_exp(input word_t w, input int unsigned exp_w, input int unsigned man_w);
    return (w >> man_w) & field_mask(exp_w);
  endfunction

  function automatic word_t fp_man(input word_t w, input int unsigned man_w);
    return w & field_mask(man_w);
  endfunction

  function automatic logic is_nan(input word_t w, input int unsigned exp_w, input int unsigned man_w);
    return (fp_exp(w, exp_w, man_w) == field_mask(exp_w)) && (fp_man(w, man_w) != '0);
  endfunction

  function automatic logic is_snan(input word_t w, input int unsigned exp_w, input int unsigned man_w);
    word_t t;
    t = w >> (man_w - 1);
    return is_nan(w, exp_w, man_w) && !t[0];
  endfunction

  function automatic logic is_inf(input word_t w, input int unsigned exp_w, input int unsigned man_w);
    return (fp_exp(w, exp_w, man_w) == field_mask(exp_w)) && (fp_man(w, man_w) == '0);
  endfunction

  // Zero exponent covers subnormals too, since they are flushed to zero.
  function automatic logic is_zero(input word_t w, input int unsigned exp_w, input int unsigned man_w);
    return fp_exp(w, exp_w, man_w) == '0;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
  parameter int unsigned WIDTH = 27
) (
  input  logic [WIDTH-1:0]             in,
  output logic [$clog2(WIDTH+1)-1:0]   count
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic found;

  always_comb begin
    count = CW'(WIDTH);
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && in[WIDTH-1-i]) begin
        count = CW'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpu_addsub_unit.sv
// Multi-cycle IEEE-754 adder/subtractor with RNE rounding, flush-to-zero and fixed 6-cycle latency.
module fpu_addsub_unit
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic [EXP_W+MAN_W:0]     a_in,
  input  logic [EXP_W+MAN_W:0]     b_in,
  output logic                     busy,
  output logic                     done,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [3:0]               flags
);
  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned EXT_W = SIG_W + 3;
  localparam int unsigned SUM_W = EXT_W + 1;
  localparam int unsigned LZW   = $clog2(EXT_W + 1);
  localparam int unsigned EW    = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  state_t state_q, state_d;

  logic [W-1:0]           a_q, b_q;
  logic                   sub_q;
  logic                   byp_r;
  logic [W-1:0]           byp_val_r;
  logic [3:0]             byp_fl_r;
  logic                   x_s_r, eff_sub_r;
  logic [EXP_W-1:0]       x_e_r, diff_r;
  logic [SIG_W-1:0]       x_sig_r, y_sig_r;
  logic [EXT_W-1:0]       x_al_r, y_al_r;
  logic [SUM_W-1:0]       sum_r;
  logic [EXT_W-1:0]       n_sig_r;
  logic signed [EW-1:0]   n_e_r;
  logic                   n_zero_r;

  logic                   a_s, b_s, a_zero, b_zero, a_ge, eff_sub;
  logic [EXP_W-1:0]       a_e, b_e;
  logic [SIG_W-1:0]       a_sig, b_sig;
  logic                   u_byp;
  logic [W-1:0]           u_byp_val;
  logic [3:0]             u_byp_fl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_UNPACK;
      S_UNPACK: state_d = S_ALIGN;
      S_ALIGN:  state_d = S_ADD;
      S_ADD:    state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb busy = (state_q != S_IDLE);

  // Unpack: flush subnormals, fold op_sub into B's sign, order by magnitude, classify specials.
  always_comb begin
    a_s    = fp_sign(word_t'(a_q), EXP_W, MAN_W);
    b_s    = fp_sign(word_t'(b_q), EXP_W, MAN_W) ^ sub_q;
    a_e    = EXP_W'(fp_exp(word_t'(a_q), EXP_W, MAN_W));
    b_e    = EXP_W'(fp_exp(word_t'(b_q), EXP_W, MAN_W));
    a_zero = is_zero(word_t'(a_q), EXP_W, MAN_W);
    b_zero = is_zero(word_t'(b_q), EXP_W, MAN_W);
    a_sig  = a_zero ? '0 : {1'b1, MAN_W'(fp_man(word_t'(a_q), MAN_W))};
    b_sig  = b_zero ? '0 : {1'b1, MAN_W'(fp_man(word_t'(b_q), MAN_W))};
    a_ge   = {a_e, a_sig} >= {b_e, b_sig};
    eff_sub = a_s ^ b_s;

    u_byp     = 1'b0;
    u_byp_val = '0;
    u_byp_fl  = '0;
    if (is_nan(word_t'(a_q), EXP_W, MAN_W) || is_nan(word_t'(b_q), EXP_W, MAN_W)) begin
      u_byp     = 1'b1;
      u_byp_val = W'(qnan(EXP_W, MAN_W));
      u_byp_fl[FLAG_INVALID] = is_snan(word_t'(a_q), EXP_W, MAN_W) || is_snan(word_t'(b_q), EXP_W, MAN_W);
    end else if (is_inf(word_t'(a_q), EXP_W, MAN_W) && is_inf(word_t'(b_q), EXP_W, MAN_W) && eff_sub) begin
      u_byp     = 1'b1;
      u_byp_val = W'(qnan(EXP_W, MAN_W));
      u_byp_fl[FLAG_INVALID] = 1'b1;
    end else if (is_inf(word_t'(a_q), EXP_W, MAN_W)) begin
      u_byp     = 1'b1;
      u_byp_val = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (is_inf(word_t'(b_q), EXP_W, MAN_W)) begin
      u_byp     = 1'b1;
      u_byp_val = {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      u_byp     = 1'b1;
      u_byp_val = {a_s & b_s, {(W-1){1'b0}}};
    end
  end

  logic [EXT_W-1:0] y_ext, y_mask, y_al_d;
  logic             y_lost;

  always_comb begin
    y_ext  = {y_sig_r, 3'b000};
    y_mask = '0;
    y_lost = 1'b0;
    if (32'(diff_r) >= EXT_W) begin
      y_al_d = {{(EXT_W-1){1'b0}}, |y_sig_r};
    end else begin
      y_mask = ~({EXT_W{1'b1}} << diff_r);
      y_lost = |(y_ext & y_mask);
      y_al_d = (y_ext >> diff_r) | {{(EXT_W-1){1'b0}}, y_lost};
    end
  end

  logic [SUM_W-1:0] sum_d;
  always_comb begin
    if (eff_sub_r) sum_d = {1'b0, x_al_r} - {1'b0, y_al_r};
    else           sum_d = {1'b0, x_al_r} + {1'b0, y_al_r};
  end

  logic [LZW-1:0]       lz;
  logic [EXT_W-1:0]     n_sig_d;
  logic signed [EW-1:0] n_e_d;

  fpu_lzc #(.WIDTH(EXT_W)) u_lzc (
    .in    (sum_r[EXT_W-1:0]),
    .count (lz)
  );

  always_comb begin
    if (sum_r[SUM_W-1]) begin
      n_sig_d = sum_r[SUM_W-1:1] | {{(EXT_W-1){1'b0}}, sum_r[0]};
      n_e_d   = EW'(x_e_r) + EW'(1);
    end else begin
      n_sig_d = sum_r[EXT_W-1:0] << lz;
      n_e_d   = EW'(x_e_r) - EW'(lz);
    end
  end

  logic [SIG_W-1:0]     man_sig;
  logic [SIG_W:0]       rnd;
  logic                 g, r, st, inexact;
  logic [MAN_W-1:0]     r_man;
  logic signed [EW-1:0] r_e;
  logic [W-1:0]         r_result;
  logic [3:0]           r_flags;

  always_comb begin
    man_sig = n_sig_r[EXT_W-1:3];
    g       = n_sig_r[2];
    r       = n_sig_r[1];
    st      = n_sig_r[0];
    inexact = g | r | st;
    rnd     = {1'b0, man_sig} + {{SIG_W{1'b0}}, g & (r | st | man_sig[0])};
    r_man   = rnd[SIG_W] ? rnd[SIG_W-1:1] : rnd[MAN_W-1:0];
    r_e     = n_e_r + EW'(rnd[SIG_W]);
    r_result = '0;
    r_flags  = '0;
    if (byp_r) begin
      r_result = byp_val_r;
      r_flags  = byp_fl_r;
    end else if (n_zero_r) begin
      r_result = '0;
    end else if (r_e >= EMAX) begin
      r_result = {x_s_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r_flags[FLAG_OVERFLOW] = 1'b1;
      r_flags[FLAG_INEXACT]  = 1'b1;
    end else if (r_e <= 0) begin
      r_result = {x_s_r, {(W-1){1'b0}}};
      r_flags[FLAG_UNDERFLOW] = 1'b1;
      r_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      r_result = {x_s_r, r_e[EXP_W-1:0], r_man};
      r_flags[FLAG_INEXACT] = inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      byp_r     <= 1'b0;
      byp_val_r <= '0;
      byp_fl_r  <= '0;
      x_s_r     <= 1'b0;
      eff_sub_r <= 1'b0;
      x_e_r     <= '0;
      diff_r    <= '0;
      x_sig_r   <= '0;
      y_sig_r   <= '0;
      x_al_r    <= '0;
      y_al_r    <= '0;
      sum_r     <= '0;
      n_sig_r   <= '0;
      n_e_r     <= '0;
      n_zero_r  <= 1'b0;
      result    <= '0;
      flags     <= '0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          a_q   <= a_in;
          b_q   <= b_in;
          sub_q <= op_sub;
        end
        S_UNPACK: begin
          byp_r     <= u_byp;
          byp_val_r <= u_byp_val;
          byp_fl_r  <= u_byp_fl;
          eff_sub_r <= eff_sub;
          x_s_r     <= a_ge ? a_s : b_s;
          x_e_r     <= a_ge ? a_e : b_e;
          diff_r    <= a_ge ? (a_e - b_e) : (b_e - a_e);
          x_sig_r   <= a_ge ? a_sig : b_sig;
          y_sig_r   <= a_ge ? b_sig : a_sig;
        end
        S_ALIGN: begin
          x_al_r <= {x_sig_r, 3'b000};
          y_al_r <= y_al_d;
        end
        S_ADD: sum_r <= sum_d;
        S_NORM: begin
          n_sig_r  <= n_sig_d;
          n_e_r    <= n_e_d;
          n_zero_r <= (sum_r == '0);
        end
        S_ROUND: begin
          result <= r_result;
          flags  <= r_flags;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
